// File: rtl/clk_reset_seq.sv
// Core-domain sequencer: qualifies the PLL lock, holds the system reset for a
// programmable time, then emits phase-aligned clock-enable strobes.
module clk_reset_seq #(
  parameter int                        NUM_CH      = 2,
  parameter int                        DIV_W       = 8,
  parameter logic [NUM_CH*DIV_W-1:0]   DIVS        = {8'd27, 8'd4},
  parameter int                        LOCK_CYCLES = 1024,
  parameter int                        RST_HOLD    = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pll_lock,
  input  logic              req_reset,
  output logic              ready,
  output logic              sys_rst_n,
  output logic [NUM_CH-1:0] ce,
  output logic [7:0]        loss_cnt
);

  localparam int MAX_CYC = (LOCK_CYCLES > RST_HOLD) ? LOCK_CYCLES : RST_HOLD;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD - 1);

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_QUALIFY,
    ST_HOLD,
    ST_RUN
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       loss_q, loss_d;
  logic             ready_q, ready_d;
  logic             sys_rst_n_q, sys_rst_n_d;
  logic             lock_s;
  logic             run_stay;

  assign lock_s = sync_q[1];

  always_comb begin
    sync_d      = {sync_q[0], pll_lock};
    state_d     = state_q;
    cnt_d       = cnt_q;
    loss_d      = loss_q;
    // A software request overrides everything, including a coincident loss.
    if (req_reset) begin
      state_d = ST_WAIT;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_WAIT: begin
          if (lock_s) begin
            state_d = ST_QUALIFY;
            cnt_d   = '0;
          end
        end
        ST_QUALIFY: begin
          if (!lock_s) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
          end else if (cnt_q == LOCK_LAST) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (!lock_s) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
            loss_d  = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
          end else if (cnt_q == HOLD_LAST) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
            loss_d  = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
          end
        end
        default: begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
      endcase
    end
    ready_d     = (state_d == ST_HOLD) || (state_d == ST_RUN);
    sys_rst_n_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      state_q     <= ST_WAIT;
      cnt_q       <= '0;
      loss_q      <= '0;
      ready_q     <= 1'b0;
      sys_rst_n_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      loss_q      <= loss_d;
      ready_q     <= ready_d;
      sys_rst_n_q <= sys_rst_n_d;
    end
  end

  // Dividers only advance while RUN persists; any entry to RUN restarts them at 0.
  assign run_stay = (state_q == ST_RUN) && (state_d == ST_RUN);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [DIV_W-1:0] DIV_LAST = DIVS[i*DIV_W +: DIV_W] - DIV_W'(1);

    logic [DIV_W-1:0] c_q, c_d;
    logic             ce_q, ce_d;

    always_comb begin
      c_d  = '0;
      ce_d = 1'b0;
      if (run_stay) begin
        if (c_q == DIV_LAST) begin
          ce_d = 1'b1;
        end else begin
          c_d = c_q + DIV_W'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        c_q  <= '0;
        ce_q <= 1'b0;
      end else begin
        c_q  <= c_d;
        ce_q <= ce_d;
      end
    end

    assign ce[i] = ce_q;
  end

  assign ready     = ready_q;
  assign sys_rst_n = sys_rst_n_q;
  assign loss_cnt  = loss_q;

endmodule

// File: tb/tb_clk_reset_seq.sv
// Bench for clk_reset_seq: event-time reference model compared every cycle,
// plus directed bring-up, loss, request, divider and async-reset scenarios.
module tb_clk_reset_seq;

  localparam int NUM_CH = 4;
  localparam int DIV_W  = 8;
  localparam int LC     = 16;
  localparam int RH     = 8;

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b0;
  logic              pll_lock  = 1'b0;
  logic              req_reset = 1'b0;
  logic              ready;
  logic              sys_rst_n;
  logic [NUM_CH-1:0] ce;
  logic [7:0]        loss_cnt;

  int vectors     = 0;
  int miscompares = 0;
  int ecnt        = 0;
  int base        = 0;
  bit chk_en      = 1'b0;

  // channel 0 = /4, 1 = /27, 2 = /3, 3 = /1
  clk_reset_seq #(
    .NUM_CH     (NUM_CH),
    .DIV_W      (DIV_W),
    .DIVS       ({8'd1, 8'd3, 8'd27, 8'd4}),
    .LOCK_CYCLES(LC),
    .RST_HOLD   (RH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pll_lock (pll_lock),
    .req_reset(req_reset),
    .ready    (ready),
    .sys_rst_n(sys_rst_n),
    .ce       (ce),
    .loss_cnt (loss_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ecnt <= ecnt + 1;

  function automatic int div_of(input int i);
    case (i)
      0:       return 4;
      1:       return 27;
      2:       return 3;
      default: return 1;
    endcase
  endfunction

  // Reference model: a sequence is "active" from the edge QUALIFY is entered
  // (m_qs); every output is then a function of the elapsed edge count.
  bit                m_s1, m_ls, m_act;
  int                m_qs;
  logic [7:0]        m_loss;
  bit                m_ready, m_srst;
  logic [NUM_CH-1:0] m_ce;

  always @(posedge clk or negedge rst_n) begin
    int n;
    int r;
    if (!rst_n) begin
      m_s1 = 1'b0; m_ls = 1'b0; m_act = 1'b0; m_qs = 0; m_loss = 8'd0;
      m_ready = 1'b0; m_srst = 1'b0; m_ce = '0;
    end else begin
      n = ecnt;
      if (req_reset) begin
        m_act = 1'b0;
      end else if (!m_act) begin
        if (m_ls) begin
          m_act = 1'b1;
          m_qs  = n;
        end
      end else if (!m_ls) begin
        if (n > m_qs + LC && m_loss != 8'd255) m_loss = m_loss + 8'd1;
        m_act = 1'b0;
      end
      r       = m_qs + LC + RH;
      m_ready = m_act && (n >= m_qs + LC);
      m_srst  = m_act && (n >= r);
      for (int i = 0; i < NUM_CH; i++)
        m_ce[i] = m_act && (n > r) && (((n - r) % div_of(i)) == 0);
      m_ls = m_s1;
      m_s1 = pll_lock;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      vectors++;
      if (ready !== m_ready || sys_rst_n !== m_srst || ce !== m_ce || loss_cnt !== m_loss) begin
        miscompares++;
        $display("FAIL model edge%0d: got rdy=%b srst=%b ce=%b loss=%0d, expected rdy=%b srst=%b ce=%b loss=%0d",
                 ecnt - 1, ready, sys_rst_n, ce, loss_cnt, m_ready, m_srst, m_ce, m_loss);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic after_edge(input int e);
    while (ecnt - 1 < base + e) @(negedge clk);
  endtask

  task automatic lock_on();
    pll_lock = 1'b1;
    base     = ecnt;
  endtask

  task automatic chk_all_zero(input string tag, input bit with_loss);
    chk({tag, "_ready"}, int'(ready), 0);
    chk({tag, "_srst"}, int'(sys_rst_n), 0);
    chk({tag, "_ce"}, int'(ce), 0);
    if (with_loss) chk({tag, "_loss"}, int'(loss_cnt), 0);
  endtask

  task automatic async_rst(input string tag);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_all_zero(tag, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    base  = ecnt;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk_all_zero("reset", 1'b1);

    // Nominal bring-up: lock high from edge 0
    rst_n = 1'b1;
    lock_on();
    after_edge(17); chk("nom_ready_e17", int'(ready), 0);
    after_edge(18); chk("nom_ready_e18", int'(ready), 1);
                    chk("nom_srst_e18", int'(sys_rst_n), 0);
    after_edge(25); chk("nom_srst_e25", int'(sys_rst_n), 0);
    after_edge(26); chk("nom_srst_e26", int'(sys_rst_n), 1);
                    chk("nom_div1_e26", int'(ce[3]), 0);
    after_edge(27); chk("nom_div1_e27", int'(ce[3]), 1);
                    chk("nom_ce0_e27", int'(ce[0]), 0);
    after_edge(29); chk("nom_ce2_e29", int'(ce[2]), 1);
                    chk("nom_ce0_e29", int'(ce[0]), 0);
    after_edge(30); chk("nom_ce0_e30", int'(ce[0]), 1);
    after_edge(31); chk("nom_ce0_e31", int'(ce[0]), 0);
    after_edge(34); chk("nom_ce0_e34", int'(ce[0]), 1);
    after_edge(38); chk("nom_ce0_e38", int'(ce[0]), 1);
    after_edge(52); chk("nom_ce1_e52", int'(ce[1]), 0);
    after_edge(53); chk("nom_ce1_e53", int'(ce[1]), 1);
    after_edge(80); chk("nom_ce1_e80", int'(ce[1]), 1);

    // Loss in RUN: lock sampled low at edge 100
    after_edge(99);  pll_lock = 1'b0;
    after_edge(101); chk("loss_ready_e101", int'(ready), 1);
    after_edge(102); chk_all_zero("loss_e102", 1'b0);
                     chk("loss_cnt_e102", int'(loss_cnt), 1);

    // Glitch during QUALIFY: low for the single sample at edge 10
    lock_on();
    after_edge(9);  pll_lock = 1'b0;
    after_edge(10); pll_lock = 1'b1;
    after_edge(18); chk("glitch_ready_e18", int'(ready), 0);
    after_edge(28); chk("glitch_ready_e28", int'(ready), 0);
    after_edge(29); chk("glitch_ready_e29", int'(ready), 1);
                    chk("glitch_loss", int'(loss_cnt), 1);

    // Software re-sequence: request sampled at edges 41..43
    after_edge(40); chk("req_srst_e40", int'(sys_rst_n), 1);
    req_reset = 1'b1;
    after_edge(41); chk_all_zero("req_e41", 1'b0);
                    chk("req_loss_e41", int'(loss_cnt), 1);
    after_edge(43); req_reset = 1'b0;
    after_edge(67); chk("req_srst_e67", int'(sys_rst_n), 0);
    after_edge(68); chk("req_srst_e68", int'(sys_rst_n), 1);

    // Lock loss and request seen on the same edge (83)
    after_edge(80); pll_lock  = 1'b0;
    after_edge(82); req_reset = 1'b1;
    after_edge(83); chk("simul_ready_e83", int'(ready), 0);
                    chk("simul_loss_e83", int'(loss_cnt), 1);
    after_edge(85); req_reset = 1'b0;
    lock_on();
    after_edge(18); chk("simul_relock_ready", int'(ready), 1);
                    chk("simul_loss_after", int'(loss_cnt), 1);

    // Async reset in HOLD, then a fresh sequence
    after_edge(21);
    async_rst("arst_hold");
    after_edge(17); chk("arst_ready_e17", int'(ready), 0);
    after_edge(18); chk("arst_ready_e18", int'(ready), 1);
    after_edge(26); chk("arst_srst_e26", int'(sys_rst_n), 1);

    // Randomised lock/request activity
    for (int c = 0; c < 3000; c++) begin
      if (pll_lock) begin
        if ($urandom_range(0, 49) == 0) pll_lock = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        pll_lock = 1'b1;
      end
      if (req_reset) begin
        if ($urandom_range(0, 1) == 0) req_reset = 1'b0;
      end else if ($urandom_range(0, 149) == 0) begin
        req_reset = 1'b1;
      end
      @(negedge clk);
    end

    // Async reset in RUN
    pll_lock  = 1'b0;
    req_reset = 1'b0;
    repeat (4) @(negedge clk);
    lock_on();
    after_edge(40); chk("run_srst_e40", int'(sys_rst_n), 1);
    async_rst("arst_run");

    // Repeated loss after qualification drives the counter into saturation
    pll_lock = 1'b0;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 300; k++) begin
      lock_on();
      after_edge(18 + int'($urandom_range(0, 20)));
      pll_lock = 1'b0;
      repeat (4) @(negedge clk);
      if (k == 0) chk("sat_first_loss", int'(loss_cnt), 1);
    end
    chk("sat_loss_255", int'(loss_cnt), 255);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/clk_reset_seq.md
# clk_reset_seq

Clock-domain sequencer for the 108 MHz core domain, driven by the PLL output clock. It qualifies the PLL lock flag and releases a synchronous system reset after a programmable hold time. It then generates NUM_CH phase-aligned, parametrised clock-enable strobes so cartridge logic runs at sub-rates without extra PLL outputs. It also counts lock losses and supports a software-requested re-sequence.

## Interface
- NUM_CH, 2: number of clock-enable channels (1..8)
- DIV_W, 8: width of each divider field
- DIVS, {8'd27, 8'd4}: packed NUM_CH*DIV_W divisors; channel i = DIVS[i*DIV_W +: DIV_W], each ≥1
- LOCK_CYCLES, 1024: consecutive synchronised-lock cycles required (≥1)
- RST_HOLD, 256: cycles sys_rst_n stays low after ready (≥1)

Ports:
- clk  in  1  core clock (PLL clkout, 108 MHz)
- rst_n  in  1  asynchronous, active-low reset
- pll_lock  in  1  raw PLL lock, asynchronous to clk
- req_reset  in  1  synchronous level request to re-sequence
- ready  out  1  lock qualified (HOLD or RUN)
- sys_rst_n  out  1  synchronous active-low reset to the core (high only in RUN)
- ce  out  NUM_CH  one-cycle enable strobes
- loss_cnt  out  8  saturating count of lock losses after qualification

## Operation
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. Asserting rst_n clears all flops: sync flops 0, state WAIT, counters 0, ready 0, sys_rst_n 0, ce 0, loss_cnt 0.
- pll_lock passes through a 2-flop synchroniser. The second flop output is lock_s. Only lock_s is used internally.
- States:
  - WAIT: if lock_s, go to QUALIFY with cnt=0.
  - QUALIFY: if !lock_s, go to WAIT with no loss counted. Else if cnt==LOCK_CYCLES-1, go to HOLD with cnt=0. Else cnt++.
  - HOLD: if cnt==RST_HOLD-1, go to RUN and clear all divider counters. Else cnt++.
  - RUN: steady state.
- Loss: lock_s low in HOLD or RUN sends the state to WAIT. loss_cnt increments and saturates at 255.
- req_reset high forces WAIT from any state and holds it there while high. It does not increment loss_cnt. If req_reset and a lock loss occur in the same cycle, req_reset wins and no count is taken.
- Outputs are registered and decoded from the next state:
  - ready = (HOLD or RUN)
  - sys_rst_n = RUN
- Dividers:
  - Only in RUN, on each edge: if c_i==DIV_i-1, then c_i=0 and ce[i]=1; else c_i++ and ce[i]=0.
  - Outside RUN, c_i=0 and ce[i]=0.
  - DIV_i=1 gives ce[i] continuously high in RUN.
  - All channels restart aligned on every entry to RUN.
- The shared sequencing counter is wide enough for max(LOCK_CYCLES, RST_HOLD)-1.

## Timing
- Edge 0 is the first edge sampling pll_lock high with req_reset low and lock stable. Event times are measured in cycles from edge 0:
  - lock_s high after edge 1.
  - QUALIFY entered at edge 2.
  - ready high after edge LOCK_CYCLES+2.
  - sys_rst_n high after edge LOCK_CYCLES+2+RST_HOLD (call it edge R).
  - First ce[i] high after edge R+DIV_i, for exactly one cycle.
  - Subsequent ce[i] pulses follow every DIV_i cycles.
- Lock loss: pll_lock sampled low at edge k gives lock_s low after edge k+1. After edge k+2:
  - ready, sys_rst_n and ce are 0.
  - loss_cnt has been incremented by exactly 1.
- req_reset sampled high at edge k: after edge k, ready, sys_rst_n and ce are 0. Re-qualification starts at the first edge with req_reset low and lock_s high, with the same latencies as above.
- Lock glitch during QUALIFY: the count restarts from 0, i.e. the full LOCK_CYCLES is needed again.
- Asynchronous rst_n assertion mid-sequence: all outputs are 0 immediately, with no clock required.

## Test plan
- Nominal bring-up, LOCK_CYCLES=16, RST_HOLD=8, DIVS={27,4}, pll_lock high from edge 0:
  - ready rises after edge 18.
  - sys_rst_n rises after edge 26.
  - ce[0] pulses after edges 30, 34, 38.
  - ce[1] pulses after edges 53, 80.
- QUALIFY glitch: pll_lock low for 1 cycle at edge 10, then high:
  - ready does not rise at edge 18.
  - ready rises 16 cycles after re-entry to QUALIFY.
  - loss_cnt stays 0.
- Loss in RUN: drop pll_lock at edge 100:
  - After edge 102, ready=0, sys_rst_n=0, ce=0, loss_cnt=1.
  - Relock gives full re-sequence; repeat 300 times → loss_cnt saturates at 255.
- req_reset: pulse for 3 cycles in RUN:
  - Outputs go 0 on the next edge; loss_cnt unchanged.
  - sys_rst_n returns LOCK_CYCLES+RST_HOLD+1 cycles after req_reset falls.
  - Simultaneous lock drop plus req_reset leaves loss_cnt unchanged.
- DIV=1 channel: DIVS={1,3}:
  - ce[1] is high on every cycle of RUN starting one cycle after sys_rst_n rises.
  - ce[0] pulses every 3 cycles.
- Asynchronous reset: assert rst_n between clock edges in HOLD and in RUN:
  - All outputs and loss_cnt are 0 before the next edge.
  - After release, the sequence restarts from WAIT.
